gat_load_ctrl: RTL
==================

# gat_load_ctrl

Parametrised load/run/readout controller placed between the PS-side AXI-BRAM ports and `gat_top`. It replaces the fixed single-purpose port adapter used so far, and it does three jobs:
- translates NUM_CH byte-addressed 32-bit write channels into word-addressed core BRAM writes;
- tracks per-channel load completion against runtime lengths and launches the core;
- gates and pipelines feature readback.

It raises `gat_ready`-style status itself instead of relying on software-driven `*_load_done` strobes.

## Interface
Parameters:
- TOP_WIDTH, 32, PS-side data width.
- NUM_CH, 4, number of write channels (h_data, h_node_info, wgt, subgraph).
- ADDR_W, 19, word-address width per channel; PS byte address is ADDR_W+2 bits.
- CNT_W, 20, width of per-channel length/counter.
- RD_ADDR_W, 16, feature-BRAM word-address width.
- RD_LAT, 1, feature-BRAM read latency in cycles (≥1).

Ports:
- clk  in  1  sole clock.
- rst  in  1  reset: one clock; reset is synchronous and active-high.
- start  in  1  single-cycle pulse; begins a load session.
- cfg_len  in  NUM_CH*CNT_W  expected word count per channel, sampled on accepted start.
- s_din  in  NUM_CH*TOP_WIDTH  PS write data.
- s_ena, s_wea  in  NUM_CH each  PS enable / write enable.
- s_addra  in  NUM_CH*(ADDR_W+2)  PS byte address.
- m_din  out  NUM_CH*TOP_WIDTH  core write data; core slices the low bits.
- m_wea  out  NUM_CH  core write strobe.
- m_addra  out  NUM_CH*ADDR_W  core word address.
- load_done  out  NUM_CH  per-channel complete.
- core_start  out  1  one-cycle launch pulse to gat_top.
- core_ready  in  1  gat_top idle/finished level.
- busy  out  1  state ≠ IDLE and ≠ DONE.
- done  out  1  state == DONE.
- err  out  1  sticky error.
- err_ch  out  NUM_CH  sticky per-channel error.
- rd_en  in  1  feature read request.
- rd_addrb  in  RD_ADDR_W+2  byte address.
- core_addrb  out  RD_ADDR_W  to feature BRAM.
- core_dout  in  TOP_WIDTH  feature BRAM data.
- rd_dout  out  TOP_WIDTH  readback data.
- rd_valid  out  1  readback data valid.

## Operation
- FSM states: IDLE → LOAD → RUN_LO → RUN_HI → DONE. DONE → LOAD on start.
- Reset state is IDLE. Every output resets to 0 and all counters clear.
- IDLE/DONE + start:
  - latch cfg_len;
  - clear counters, load_done, err, err_ch;
  - enter LOAD.
- start in LOAD/RUN_LO/RUN_HI is ignored and sets err.
- Write acceptance on channel c requires all of: state==LOAD, s_ena[c]&s_wea[c], s_addra[c][1:0]==0, cnt[c] < len[c].
- Accepted write:
  - m_addra = s_addra[ADDR_W+1:2];
  - m_din = s_din;
  - m_wea pulses;
  - cnt[c]++.
- Rejected write (any of the conditions above fails while s_ena&s_wea): no m_wea, sets err_ch[c] and err.
- s_ena with s_wea=0 is ignored silently.
- load_done[c] = (cnt[c]==len[c]), evaluated in LOAD, RUN_LO, RUN_HI and DONE. A length of 0 gives done on the first LOAD cycle.
- LOAD → RUN_LO when &load_done; core_start pulses on that transition.
- RUN_LO waits for core_ready==0, which guards against a stale ready. RUN_HI waits for core_ready==1, then goes to DONE.
- Readback is active only in DONE:
  - rd_en registers core_addrb = rd_addrb[RD_ADDR_W+1:2];
  - rd_en outside DONE is dropped, no rd_valid, err unchanged.
- Multiple channels may write in the same cycle independently. Channels are never arbitrated.

## Timing
- Write path latency: 1 cycle. All m_* outputs are registered from the s_* inputs of the previous cycle.
- load_done[c] rises the cycle after the final accepted write reaches the counter. core_start fires the cycle after the last load_done rises.
- core_start is exactly 1 cycle.
- RUN_HI → DONE takes 1 cycle after core_ready is sampled high.
- Read: rd_en sampled at edge N → core_addrb valid from N+1 → core_dout valid at N+1+RD_LAT → rd_dout and rd_valid at N+2+RD_LAT. rd_valid lasts 1 cycle per request.
- Back-to-back reads are fully pipelined: one result per cycle, in order.
- Reads issued in the last DONE cycle before a start still complete.
- rst mid-operation: the next cycle is IDLE, all outputs are 0, and the in-flight read pipeline is flushed (no rd_valid).

## Structure
- Shared package `gat_pkg`:
  - state enum `load_state_e`;
  - constants `BYTE_OFS=2`, `DEFAULT_NUM_CH=4`.
- One sub-module `gat_load_ch`, instantiated NUM_CH times by generate. It holds the per-channel counter, acceptance check, write register and err/done flags.
- The top level holds the FSM, the launch logic, and the read pipeline (RD_LAT+1 stage valid shift register).

## Test plan
- Nominal: reset, start with len={3,2,4,1}, write all words aligned. Expect m_wea count to equal len per channel, m_addra = byte_addr>>2 (0x0C → 3), core_start one pulse 1 cycle after the last load_done, err=0.
- Overrun/misalign: len[0]=2, write 3 words, then byte address 0x06 on ch1. Expect only 2 m_wea on ch0, err_ch=4'b0011, err=1, FSM still completes once ch1 gets its valid words.
- Stale ready: core_ready held high through launch. Expect FSM to stay in RUN_LO until ready drops, then reach DONE only after ready re-rises.
- Readback: in DONE, rd_en on 4 consecutive cycles with addresses 0x0, 0x4, 0x8, 0xC and RD_LAT=1. Expect core_addrb 0..3, rd_valid on cycles N+3..N+6 with matching data. rd_en in LOAD gives no rd_valid.
- Zero length: len={0,0,0,0}. Expect load_done=4'hF on the first LOAD cycle and core_start on the next.
- Reset mid-LOAD after 1 write. Expect all outputs 0 the next cycle, and a fresh start with new lengths counting from 0.

Source files
------------

// File: rtl/gat_pkg.sv
// rtl/gat_pkg.sv - shared FSM type and constants for the GAT load/run/readout controller
package gat_pkg;

    // Controller session states; IDLE only after reset, DONE loops back to LOAD on start.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN_LO = 3'd2,
        ST_RUN_HI = 3'd3,
        ST_DONE   = 3'd4
    } load_state_e;

    // PS addresses are byte addresses; the low BYTE_OFS bits select a byte within a word.
    localparam int BYTE_OFS       = 2;
    localparam int DEFAULT_NUM_CH = 4;

    // States in which a session is in progress (start is illegal, busy is high).
    function automatic logic is_active(load_state_e s);
        return (s == ST_LOAD) || (s == ST_RUN_LO) || (s == ST_RUN_HI);
    endfunction

endpackage

// File: rtl/gat_load_ch.sv
// rtl/gat_load_ch.sv - one write channel: acceptance check, word counter, registered core write
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clear         accepted start: reload length, clear counter and flags
//   load_en       controller is in LOAD (writes may be accepted)
//   len_in        expected word count, captured on clear
//   s_din/s_ena/s_wea/s_addra   PS-side byte-addressed write port
//   m_din/m_wea/m_addra         registered word-addressed core write
//   load_done     counter has reached the captured length
//   err_ch        sticky: a write on this channel was rejected
//   wr_rej        combinational: a write is being rejected this cycle
module gat_load_ch
    import gat_pkg::*;
#(
    parameter int TOP_WIDTH = 32,
    parameter int ADDR_W    = 19,
    parameter int CNT_W     = 20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       load_en,
    input  logic [CNT_W-1:0]           len_in,
    input  logic [TOP_WIDTH-1:0]       s_din,
    input  logic                       s_ena,
    input  logic                       s_wea,
    input  logic [ADDR_W+BYTE_OFS-1:0] s_addra,
    output logic [TOP_WIDTH-1:0]       m_din,
    output logic                       m_wea,
    output logic [ADDR_W-1:0]          m_addra,
    output logic                       load_done,
    output logic                       err_ch,
    output logic                       wr_rej
);

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     len_q, len_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 m_wea_q, m_wea_d;
    logic [ADDR_W-1:0]    m_addra_q, m_addra_d;
    logic [TOP_WIDTH-1:0] m_din_q, m_din_d;
    logic                 wr_req;
    logic                 accept;

    always_comb begin
        wr_req = s_ena & s_wea;
        accept = load_en & wr_req & (s_addra[BYTE_OFS-1:0] == '0) & (cnt_q < len_q);
        wr_rej = wr_req & ~accept;

        cnt_d     = cnt_q;
        len_d     = len_q;
        done_d    = done_q;
        err_d     = err_q;
        m_wea_d   = accept;
        m_addra_d = m_addra_q;
        m_din_d   = m_din_q;

        if (accept) begin
            m_addra_d = s_addra[ADDR_W+BYTE_OFS-1:BYTE_OFS];
            m_din_d   = s_din;
        end

        if (clear) begin
            // A zero length is complete immediately, so done is known on the first LOAD cycle.
            len_d  = len_in;
            cnt_d  = '0;
            done_d = (len_in == '0);
            err_d  = 1'b0;
        end else begin
            if (accept) begin
                cnt_d = cnt_q + 1'b1;
                // Counter only moves up to len, so done is set once and held until the next clear.
                if (cnt_d == len_q) begin
                    done_d = 1'b1;
                end
            end
            if (wr_rej) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            len_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            m_wea_q   <= 1'b0;
            m_addra_q <= '0;
            m_din_q   <= '0;
        end else begin
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            done_q    <= done_d;
            err_q     <= err_d;
            m_wea_q   <= m_wea_d;
            m_addra_q <= m_addra_d;
            m_din_q   <= m_din_d;
        end
    end

    assign m_din     = m_din_q;
    assign m_wea     = m_wea_q;
    assign m_addra   = m_addra_q;
    assign load_done = done_q;
    assign err_ch    = err_q;

endmodule

// File: rtl/gat_load_ctrl.sv
// rtl/gat_load_ctrl.sv - load/run/readout controller between PS BRAM ports and gat_top
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start, cfg_len              session start pulse and per-channel word counts
//   s_din/s_ena/s_wea/s_addra   NUM_CH PS-side byte-addressed write ports
//   m_din/m_wea/m_addra         NUM_CH registered word-addressed core writes
//   load_done                   per-channel load complete
//   core_start, core_ready      launch pulse to / idle level from gat_top
//   busy, done, err, err_ch     session status and sticky errors
//   rd_en, rd_addrb             feature read request (byte address), honoured in DONE
//   core_addrb, core_dout       feature BRAM address / data (RD_LAT cycles)
//   rd_dout, rd_valid           readback result, one valid cycle per request
module gat_load_ctrl
    import gat_pkg::*;
#(
    parameter int TOP_WIDTH = 32,
    parameter int NUM_CH    = DEFAULT_NUM_CH,
    parameter int ADDR_W    = 19,
    parameter int CNT_W     = 20,
    parameter int RD_ADDR_W = 16,
    parameter int RD_LAT    = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [NUM_CH*CNT_W-1:0]             cfg_len,
    input  logic [NUM_CH*TOP_WIDTH-1:0]         s_din,
    input  logic [NUM_CH-1:0]                   s_ena,
    input  logic [NUM_CH-1:0]                   s_wea,
    input  logic [NUM_CH*(ADDR_W+BYTE_OFS)-1:0] s_addra,
    output logic [NUM_CH*TOP_WIDTH-1:0]         m_din,
    output logic [NUM_CH-1:0]                   m_wea,
    output logic [NUM_CH*ADDR_W-1:0]            m_addra,
    output logic [NUM_CH-1:0]                   load_done,
    output logic                                core_start,
    input  logic                                core_ready,
    output logic                                busy,
    output logic                                done,
    output logic                                err,
    output logic [NUM_CH-1:0]                   err_ch,
    input  logic                                rd_en,
    input  logic [RD_ADDR_W+BYTE_OFS-1:0]       rd_addrb,
    output logic [RD_ADDR_W-1:0]                core_addrb,
    input  logic [TOP_WIDTH-1:0]                core_dout,
    output logic [TOP_WIDTH-1:0]                rd_dout,
    output logic                                rd_valid
);

    load_state_e          state_q, state_d;
    logic                 core_start_q, core_start_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [RD_ADDR_W-1:0] core_addrb_q, core_addrb_d;
    logic [RD_LAT:0]      rv_q, rv_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [TOP_WIDTH-1:0] rd_dout_q, rd_dout_d;

    logic                 start_ok;
    logic                 rd_issue;
    logic                 load_en;
    logic [NUM_CH-1:0]    ch_rej;
    logic                 unused_rd_lsb;

    assign unused_rd_lsb = ^rd_addrb[BYTE_OFS-1:0];

    assign start_ok = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
    assign load_en  = (state_q == ST_LOAD);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        gat_load_ch #(
            .TOP_WIDTH (TOP_WIDTH),
            .ADDR_W    (ADDR_W),
            .CNT_W     (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .clear     (start_ok),
            .load_en   (load_en),
            .len_in    (cfg_len[c*CNT_W +: CNT_W]),
            .s_din     (s_din[c*TOP_WIDTH +: TOP_WIDTH]),
            .s_ena     (s_ena[c]),
            .s_wea     (s_wea[c]),
            .s_addra   (s_addra[c*(ADDR_W+BYTE_OFS) +: ADDR_W+BYTE_OFS]),
            .m_din     (m_din[c*TOP_WIDTH +: TOP_WIDTH]),
            .m_wea     (m_wea[c]),
            .m_addra   (m_addra[c*ADDR_W +: ADDR_W]),
            .load_done (load_done[c]),
            .err_ch    (err_ch[c]),
            .wr_rej    (ch_rej[c])
        );
    end

    always_comb begin
        state_d      = state_q;
        core_start_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (&load_done) begin
                    state_d      = ST_RUN_LO;
                    core_start_d = 1'b1;
                end
            end
            // Wait for the core to drop ready first so a ready left over from a
            // previous run is not mistaken for completion of this one.
            ST_RUN_LO: begin
                if (!core_ready) state_d = ST_RUN_HI;
            end
            ST_RUN_HI: begin
                if (core_ready) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (start) state_d = ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = is_active(state_d);
        done_d = (state_d == ST_DONE);

        if (start_ok) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q | (|ch_rej) | start;
        end

        // Reads are only taken in DONE; once issued they drain regardless of state.
        rd_issue     = rd_en & (state_q == ST_DONE);
        core_addrb_d = rd_issue ? rd_addrb[RD_ADDR_W+BYTE_OFS-1:BYTE_OFS] : core_addrb_q;
        rv_d         = {rv_q[RD_LAT-1:0], rd_issue};
        rd_valid_d   = rv_q[RD_LAT];
        rd_dout_d    = rv_q[RD_LAT] ? core_dout : rd_dout_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            core_start_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            core_addrb_q <= '0;
            rv_q         <= '0;
            rd_valid_q   <= 1'b0;
            rd_dout_q    <= '0;
        end else begin
            state_q      <= state_d;
            core_start_q <= core_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            core_addrb_q <= core_addrb_d;
            rv_q         <= rv_d;
            rd_valid_q   <= rd_valid_d;
            rd_dout_q    <= rd_dout_d;
        end
    end

    assign core_start = core_start_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign core_addrb = core_addrb_q;
    assign rd_valid   = rd_valid_q;
    assign rd_dout    = rd_dout_q;

endmodule
